sqrt_stage3: RTL and testbench

Final stage of the square-root datapath, and the consumer of the stage-2 pipeline register bank. It takes the registered low-half sum, carry and high-half operands, and finishes the split 17-bit addition. The completed value goes to the square feedback register, which the iteration stage reads. Completed results go into a 2-entry output buffer with a valid/ready handshake. The block also drives the pipeline enable, so the upstream stages stall when that buffer is full.

---
 rtl/sqrt_stage3.sv | 115 +++++++++++
 tb/tb_sqrt_stage3.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_stage3.sv
// Final square-root stage: completes the split 17-bit add, holds the square feedback
// register and buffers finished results in a 2-entry FIFO that back-pressures upstream.
module sqrt_stage3 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ready_i,
    input  logic        wr_square_s_i,
    input  logic        N_i,
    input  logic [7:0]  sum_low_i,
    input  logic        Co_i,
    input  logic [8:0]  A_high_i,
    input  logic [8:0]  B_high_i,
    output logic        en_pipe_o,
    output logic [16:0] square_o,
    output logic        result_valid_o,
    input  logic        result_ready_i,
    output logic [16:0] result_data_o,
    output logic        result_n_o,
    output logic        result_ovf_o,
    output logic [7:0]  result_cnt_o
);

    logic [9:0]       sum_high;
    logic [16:0]      sum17;
    logic             ovf;
    logic             push;
    logic             pop;
    logic             sq_wr;

    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0][16:0] data_q, data_d;
    logic [1:0]       n_q, n_d;
    logic [1:0]       ovf_q, ovf_d;
    logic [16:0]      square_q, square_d;
    logic [7:0]       cnt_q, cnt_d;

    always_comb begin
        sum_high = {1'b0, A_high_i} + {1'b0, B_high_i} + {9'd0, Co_i};
        sum17    = {sum_high[8:0], sum_low_i};
        ovf      = sum_high[9];
    end

    // Enable comes only from the registered count, so a pop while full re-opens the pipe
    // one cycle later and there is no input-to-enable combinational path.
    always_comb begin
        en_pipe_o      = (count_q != 2'd2);
        result_valid_o = (count_q != 2'd0);
        push           = en_pipe_o & ready_i;
        sq_wr          = en_pipe_o & wr_square_s_i;
        pop            = result_valid_o & result_ready_i;
    end

    always_comb begin
        data_d   = data_q;
        n_d      = n_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        square_d = square_q;
        cnt_d    = cnt_q;

        if (sq_wr) begin
            square_d = sum17;
        end
        if (push) begin
            data_d[wr_ptr_q] = sum17;
            n_d[wr_ptr_q]    = N_i;
            ovf_d[wr_ptr_q]  = ovf;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            cnt_d    = cnt_q + 8'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            n_q      <= '0;
            ovf_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            square_q <= 17'd0;
            cnt_q    <= 8'd0;
        end else begin
            data_q   <= data_d;
            n_q      <= n_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            square_q <= square_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        square_o      = square_q;
        result_data_o = data_q[rd_ptr_q];
        result_n_o    = n_q[rd_ptr_q];
        result_ovf_o  = ovf_q[rd_ptr_q];
        result_cnt_o  = cnt_q;
    end

endmodule

// File: tb/tb_sqrt_stage3.sv
// Scoreboard bench for sqrt_stage3: an arithmetic model predicts results and occupancy,
// a negedge monitor pops expectations whenever the DUT hands over a result.
module tb_sqrt_stage3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready_i = 1'b0;
    logic        wr_square_s_i = 1'b0;
    logic        N_i = 1'b0;
    logic [7:0]  sum_low_i = '0;
    logic        Co_i = 1'b0;
    logic [8:0]  A_high_i = '0;
    logic [8:0]  B_high_i = '0;
    logic        en_pipe_o;
    logic [16:0] square_o;
    logic        result_valid_o;
    logic        result_ready_i = 1'b0;
    logic [16:0] result_data_o;
    logic        result_n_o;
    logic        result_ovf_o;
    logic [7:0]  result_cnt_o;

    sqrt_stage3 dut (
        .clk(clk), .rst_n(rst_n), .ready_i(ready_i), .wr_square_s_i(wr_square_s_i),
        .N_i(N_i), .sum_low_i(sum_low_i), .Co_i(Co_i), .A_high_i(A_high_i),
        .B_high_i(B_high_i), .en_pipe_o(en_pipe_o), .square_o(square_o),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_data_o(result_data_o), .result_n_o(result_n_o),
        .result_ovf_o(result_ovf_o), .result_cnt_o(result_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] d;
        logic        n;
        logic        ovf;
    } res_t;

    res_t        exp_q[$];
    int          mcnt = 0;
    int          mpops = 0;
    logic [16:0] msq = '0;
    logic        accepted = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t compute(input logic [7:0] lo, input logic co,
                                     input logic [8:0] a, input logic [8:0] b, input logic n);
        res_t r;
        int   s;
        s     = (int'(a) + int'(b) + int'(co)) * 256 + int'(lo);
        r.d   = s[16:0];
        r.ovf = s[17];
        r.n   = n;
        return r;
    endfunction

    // Reference model: beat accepted when fewer than two results are outstanding.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            mcnt     = 0;
            mpops    = 0;
            msq      = '0;
            accepted = 1'b0;
        end else begin
            res_t r;
            bit   pop;
            r        = compute(sum_low_i, Co_i, A_high_i, B_high_i, N_i);
            accepted = (mcnt != 2);
            pop      = (mcnt != 0) && result_ready_i;
            if (accepted && wr_square_s_i) msq = r.d;
            if (accepted && ready_i) begin
                exp_q.push_back(r);
                mcnt++;
            end
            if (pop) begin
                mcnt--;
                mpops++;
            end
        end
    end

    logic        prev_valid = 1'b0;
    logic        prev_rr = 1'b0;
    logic [18:0] prev_head = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", result_valid_o, 0);
            check("rst_en_pipe", en_pipe_o, 1);
            check("rst_square", square_o, 0);
            check("rst_data", result_data_o, 0);
            check("rst_n_flag", result_n_o, 0);
            check("rst_ovf", result_ovf_o, 0);
            check("rst_cnt", result_cnt_o, 0);
            prev_valid = 1'b0;
        end else begin
            check("en_pipe", en_pipe_o, (mcnt != 2));
            check("valid", result_valid_o, (mcnt != 0));
            check("square", square_o, msq);
            check("pop_cnt", result_cnt_o, mpops % 256);
            if (prev_valid && !prev_rr && result_valid_o)
                check("head_stable", {result_data_o, result_n_o, result_ovf_o}, prev_head);
            if (result_valid_o && result_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("data", result_data_o, e.d);
                    check("n_flag", result_n_o, e.n);
                    check("ovf", result_ovf_o, e.ovf);
                end
            end
            prev_valid = result_valid_o;
            prev_rr    = result_ready_i;
            prev_head  = {result_data_o, result_n_o, result_ovf_o};
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic rdy, input logic wr, input logic n, input logic [7:0] lo,
                         input logic co, input logic [8:0] a, input logic [8:0] b);
        ready_i       = rdy;
        wr_square_s_i = wr;
        N_i           = n;
        sum_low_i     = lo;
        Co_i          = co;
        A_high_i      = a;
        B_high_i      = b;
    endtask

    task automatic drive_rand(input logic rdy, input logic wr);
        drive(rdy, wr, 1'($urandom), 8'($urandom), 1'($urandom), 9'($urandom), 9'($urandom));
    endtask

    task automatic idle();
        drive_rand(1'b0, 1'b0);
    endtask

    task automatic wait_accept();
        bit got;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (accepted) begin
                got = 1;
                break;
            end
        end
        check("accept_timeout", got, 1);
        #1;
        idle();
    endtask

    task automatic send_rand(input logic wr);
        drive_rand(1'b1, wr);
        wait_accept();
    endtask

    initial begin
        logic [7:0] cnt0;

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            drive_rand(1'($urandom), 1'($urandom));
            result_ready_i = 1'($urandom);
            sync();
        end
        idle();
        result_ready_i = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_rand(1'b0, 1'($urandom));
            sync();
        end
        check("no_valid_after_reset", result_valid_o, 0);
        idle();

        // Carry into the high half with overflow
        drive(1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 9'h1FF, 9'h001);
        wait_accept();
        @(negedge clk);
        check("carry_data", result_data_o, 17'h001A5);
        check("carry_ovf", result_ovf_o, 1);
        check("carry_n", result_n_o, 1);
        sync();
        result_ready_i = 1'b1;
        sync();
        result_ready_i = 1'b0;

        // Square feedback, then a blocked write while the buffer is full
        drive(1'b0, 1'b1, 1'b0, 8'h7F, 1'b0, 9'h012, 9'h034);
        wait_accept();
        @(negedge clk);
        check("square_write", square_o, 17'h0467F);
        sync();
        send_rand(1'b0);
        send_rand(1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 9'h100, 9'h0FF);
        repeat (3) sync();
        check("full_en_pipe", en_pipe_o, 0);
        check("square_held", square_o, 17'h0467F);
        idle();
        result_ready_i = 1'b1;
        repeat (3) sync();
        result_ready_i = 1'b0;

        // Backpressure: third beat waits until a pop frees a slot
        send_rand(1'b0);
        send_rand(1'b0);
        drive_rand(1'b1, 1'b0);
        sync();
        sync();
        check("bp_en_pipe_low", en_pipe_o, 0);
        check("bp_third_held", accepted, 0);
        result_ready_i = 1'b1;
        sync();
        result_ready_i = 1'b0;
        #1;
        check("bp_not_same_cycle", accepted, 0);
        @(negedge clk);
        check("bp_en_pipe_back", en_pipe_o, 1);
        wait_accept();
        result_ready_i = 1'b1;
        repeat (4) sync();
        result_ready_i = 1'b0;

        // Simultaneous push and pop with one entry outstanding
        send_rand(1'b0);
        cnt0 = result_cnt_o;
        result_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_rand(1'b1, 1'($urandom));
            sync();
            check("stream_en_pipe", en_pipe_o, 1);
        end
        idle();
        result_ready_i = 1'b0;
        check("stream_cnt", result_cnt_o, 8'(cnt0 + 8'd10));
        result_ready_i = 1'b1;
        repeat (3) sync();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive_rand(1'($urandom), ($urandom % 4) == 0);
            result_ready_i = ($urandom % 3) != 0;
            sync();
        end
        idle();
        result_ready_i = 1'b1;
        repeat (3) sync();
        result_ready_i = 1'b0;

        // Fill, then reset mid-cycle
        send_rand(1'b1);
        send_rand(1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", result_valid_o, 0);
        check("midrst_en_pipe", en_pipe_o, 1);
        check("midrst_square", square_o, 0);
        check("midrst_cnt", result_cnt_o, 0);
        #2;
        rst_n = 1'b1;
        sync();

        // 256 pops wrap the counter to zero
        send_rand(1'b0);
        result_ready_i = 1'b1;
        for (int i = 0; i < 255; i++) begin
            drive_rand(1'b1, 1'b0);
            sync();
        end
        idle();
        sync();
        result_ready_i = 1'b0;
        check("wrap_cnt", result_cnt_o, 0);
        check("wrap_valid", result_valid_o, 0);

        repeat (2) sync();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
